fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the instruction memory and downstream-facing to decode.
- Owns the program counter and drives the memory read address. Captures the returned word (combinational read, same cycle) into a small FIFO of {pc, instr} entries.
- Presents FIFO entries to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with FIFO flush, and backpressure via the FIFO.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 128, instruction memory size in bytes (1024-bit array); PC wraps modulo this value.
- DEPTH, 2, FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  synchronous, active-low reset.
- imem_addr  out  32  byte read address to instruction memory; equals pc (combinational from pc register).
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- redirect_valid  in  1  single-cycle request to change the fetch stream.
- redirect_target  in  32  new byte PC for redirect.
- id_valid  out  1  FIFO head entry valid.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_instr  out  32  head entry instruction.
- id_pc  out  32  head entry PC.

Behaviour:
- Reset (rstn=0 at posedge):
  - pc <= RESET_PC; FIFO count, head and tail <= 0.
  - Outputs after reset: id_valid=0, id_instr=0, id_pc=0, imem_addr=RESET_PC.
  - Entry storage is cleared to 0.
- Define pop = id_valid & id_ready.
- Define push = ~redirect_valid & (count < DEPTH | pop).
- push:
  - Write {pc, imem_data} at tail; tail <= tail+1 mod DEPTH.
  - pc <= (pc + 4) mod IMEM_BYTES.
- pop: head <= head+1 mod DEPTH.
- Count update:
  - count <= count + push - pop.
  - Push and pop in the same cycle are legal at any fill level, including full, in which case count is unchanged.
- Redirect (redirect_valid=1) takes priority over everything:
  - FIFO flushed: count, head and tail <= 0.
  - pc <= {redirect_target[31:2], 2'b00} mod IMEM_BYTES.
  - No push that cycle.
  - A simultaneous pop is a discard: the entry is considered consumed by decode, and the flush still applies.
  - id_valid=0 in the following cycle.
  - First post-redirect entry is visible 2 cycles after the redirect edge (push in cycle N+1, valid in cycle N+2).
- Latency:
  - Fetch-to-present is 1 cycle. With rstn released at edge 0, push occurs at edge 1 and id_valid=1 after edge 1 with id_pc=RESET_PC.
  - Steady-state throughput is 1 instruction/cycle while id_ready=1.
- id_valid = (count != 0). id_instr and id_pc are driven from the head entry and are stable while id_valid=1 and id_ready=0.
- Full (count==DEPTH, no pop):
  - No push; pc holds.
  - imem_addr holds, so the memory word is re-read with no side effect.
- Wrap-around:
  - pc = IMEM_BYTES-4 followed by push gives pc = 0.
  - FIFO pointers wrap modulo DEPTH.
- Misaligned targets are silently aligned down. Out-of-range targets wrap modulo IMEM_BYTES; no error output.
- Reset mid-stream: FIFO contents are discarded and pc returns to RESET_PC regardless of a concurrent redirect or pop.
- Widths:
  - pc arithmetic is 32-bit; the modulo is implemented by masking with IMEM_BYTES-1.
  - Count width is $clog2(DEPTH)+1.

Decomposition:
- Shared package (cpu_pkg):
  - Constant INSTR_W=32.
  - Constant IMEM_BYTES_DEFAULT=128.
  - Constant NOP instruction (32'h0000_0013).
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module: fetch_fifo, a DEPTH-entry synchronous FIFO with push, pop, flush, count and head outputs, where flush overrides push/pop.
- fetch_unit contains the PC register, push/redirect logic and the fetch_fifo instance.

Test Plan:
- Reset then id_ready=1 for 5 cycles; imem_data = 0x100+addr: id_pc sequence 0,4,8,12 on consecutive cycles, id_instr = 0x100,0x104,..., id_valid first high 1 cycle after reset release.
- id_ready=0 for 4 cycles from start:
  - count saturates at 2 and imem_addr holds at 8.
  - Head stays pc=0, instr=0x100.
  - On release, pcs 0,4,8 are delivered in order with no duplicate or drop.
- redirect_valid=1, target=0x2B at a cycle where FIFO holds 2 entries and pop=1:
  - Next cycle id_valid=0 and imem_addr=0x28.
  - Following cycle id_pc=0x28.
- Run to pc=0x7C with id_ready=1: next id_pc values are 0x7C then 0x00.
- Redirect target=0x84 (beyond IMEM_BYTES=128): pc becomes 0x04.
- Assert rstn=0 while full and redirect_valid=1 in the same cycle: after the edge id_valid=0 and imem_addr=0; the redirect is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and the fetch entry type used by the front end.
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int IMEM_BYTES_DEFAULT = 128;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of {pc, instr}; flush overrides push and pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);
    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  head_ptr;
    logic [PW-1:0]  tail_ptr;

    assign head = mem[head_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (push) begin
                mem[tail_ptr] <= wdata;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            if (pop) head_ptr <= head_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, reads instruction memory and queues words for decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = IMEM_BYTES_DEFAULT,
    parameter int          DEPTH      = 2
) (
    input  logic               clk,
    input  logic               rstn,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [INSTR_W-1:0] id_instr,
    output logic [31:0]        id_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] MASK = 32'(IMEM_BYTES - 1);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;
    fetch_entry_t  head;
    fetch_entry_t  wdata;

    assign imem_addr = pc;
    assign id_valid  = (count != '0);
    assign id_instr  = head.instr;
    assign id_pc     = head.pc;
    assign pop       = id_valid & id_ready;
    // A pop frees a slot this cycle, so a full queue still accepts a fetch.
    assign push      = ~redirect_valid & ((count < CW'(DEPTH)) | pop);
    assign wdata     = '{pc: pc, instr: imem_data};

    // PC: redirect wins, otherwise advance only when the fetched word was queued.
    always_ff @(posedge clk) begin
        if (!rstn) pc <= RESET_PC;
        else if (redirect_valid) pc <= {redirect_target[31:2], 2'b00} & MASK;
        else if (push) pc <= (pc + 32'd4) & MASK;
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .count (count),
        .head  (head)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a queue-based model of the fetch stream.
module tb_fetch_unit;
    localparam int DEPTH = 2;
    localparam int IMEM_BYTES = 128;

    logic        clk = 0;
    logic        rstn = 0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 0;
    logic [31:0] redirect_target = 0;
    logic        id_valid;
    logic        id_ready = 0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic [31:0] mem [IMEM_BYTES/4];
    logic [63:0] sb [$];
    int          mcount = 0;
    logic [31:0] mpc = 0;
    logic [31:0] exp_addr = 0;
    bit          live = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign imem_data = mem[imem_addr[6:2]];

    fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM_BYTES), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares presented entries against the scoreboard, away from the active edge.
    always @(negedge clk) begin
        if (live) begin
            chk("id_valid", {31'd0, id_valid}, {31'd0, sb.size() != 0});
            chk("imem_addr", imem_addr, exp_addr);
            if (id_valid && id_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_entry: got pc %h expected none", id_pc);
                end else begin
                    logic [63:0] e;
                    e = sb.pop_front();
                    chk("id_pc", id_pc, e[63:32]);
                    chk("id_instr", id_instr, e[31:0]);
                end
            end
        end
    end

    // One clock of stimulus followed by the model's view of what that edge did.
    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] tg);
        bit mpop;
        bit mpush;
        rstn = r;
        id_ready = rdy;
        redirect_valid = rv;
        redirect_target = tg;
        mpop = (mcount != 0) && rdy;
        @(posedge clk);
        if (!r) begin
            sb.delete();
            mcount = 0;
            mpc = 32'h0;
        end else if (rv) begin
            sb.delete();
            mcount = 0;
            mpc = (tg / 4 * 4) % IMEM_BYTES;
        end else begin
            mpush = (mcount < DEPTH) || mpop;
            if (mpush) begin
                sb.push_back({mpc, mem[mpc / 4]});
                mpc = (mpc + 4) % IMEM_BYTES;
            end
            mcount = mcount + int'(mpush) - int'(mpop);
        end
        exp_addr = mpc;
        live = 1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < IMEM_BYTES / 4; i++) mem[i] = 32'h100 + 32'(i * 4);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset_id_instr", id_instr, 32'h0);
        chk("reset_id_pc", id_pc, 32'h0);
        chk("reset_id_valid", {31'd0, id_valid}, 32'h0);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        chk("full_addr_hold", imem_addr, 32'h8);
        chk("full_head_pc", id_pc, 32'h0);
        chk("full_head_instr", id_instr, 32'h100);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h2B);
        chk("redirect_valid_low", {31'd0, id_valid}, 32'h0);
        chk("redirect_addr", imem_addr, 32'h28);
        step(1, 0, 0, 0);
        chk("redirect_first_pc", id_pc, 32'h28);
        for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 32'h84);
        chk("redirect_wrap_addr", imem_addr, 32'h4);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        step(0, 1, 1, 32'h40);
        chk("reset_over_redirect_valid", {31'd0, id_valid}, 32'h0);
        chk("reset_over_redirect_addr", imem_addr, 32'h0);
        for (int i = 0; i < IMEM_BYTES / 4; i++) mem[i] = $urandom;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, $urandom);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
